opo_lock_sequencer: RTL

- Acquisition/relock controller for the OPO lock-in chain.
- Consumes demodulated x/y outputs of the lock-in processing chain; drives the piezo offset sweep and PID enable.
- Sweeps the cavity offset as a triangle until resonance is captured, then hands control to the PID, supervises lock, and re-sweeps automatically on lock loss.

---
 rtl/opo_lock_pkg.sv | 30 +++
 rtl/opo_lock_sequencer_sweep_gen.sv | 113 +++++++++++
 rtl/opo_lock_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/opo_lock_pkg.sv
// opo_lock_pkg
// Shared definitions for the OPO acquisition/relock controller:
//   - lock_state_t : sequencer state encoding as seen on state_out
//   - width constants matching the default parameterisation
//   - sge          : signed greater-or-equal helper used for the y_in threshold
package opo_lock_pkg;

  localparam int CART_W   = 24;  // lock-in x/y sample width
  localparam int OFFSET_W = 14;  // piezo offset word width
  localparam int COUNT_W  = 16;  // settle/loss/divider counter width
  localparam int RELOCK_W = 8;   // saturating relock counter width
  localparam int STATE_W  = 3;   // state_out width
  localparam int CMP_W    = 64;  // width the signed compare helper works at

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    SWEEP  = 3'd1,
    SETTLE = 3'd2,
    LOCKED = 3'd3,
    FAULT  = 3'd4
  } lock_state_t;

  // Signed a >= b; callers sign-extend their operands to CMP_W first so one
  // helper serves any CART_LENGTH up to CMP_W.
  function automatic logic sge(input logic signed [CMP_W-1:0] a,
                               input logic signed [CMP_W-1:0] b);
    return (a >= b);
  endfunction

endpackage

// File: rtl/opo_lock_sequencer_sweep_gen.sv
// sweep_gen
// Triangle ramp generator for the piezo offset.
//   clk, rst       : clock, asynchronous active-low reset
//   load           : latch bounds/step/divider, restart at sweep_min going up
//   run            : ramp may advance this cycle (low = offset frozen)
//   tick           : a new lock-in sample arrived (advances the divider)
//   sweep_min/max  : ramp bounds (min > max holds the offset at min)
//   sweep_step     : offset increment per divider expiry
//   step_div       : samples per step, 0 behaves as 1
//   offset         : registered offset command
//   top_flip       : this cycle's step lands on sweep_max and turns the ramp down
module sweep_gen
  import opo_lock_pkg::*;
#(
  parameter int OFFSET_LENGTH = OFFSET_W,
  parameter int COUNT_LENGTH  = COUNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     run,
  input  logic                     tick,
  input  logic [OFFSET_LENGTH-1:0] sweep_min,
  input  logic [OFFSET_LENGTH-1:0] sweep_max,
  input  logic [OFFSET_LENGTH-1:0] sweep_step,
  input  logic [COUNT_LENGTH-1:0]  step_div,
  output logic [OFFSET_LENGTH-1:0] offset,
  output logic                     top_flip
);

  localparam int OW = OFFSET_LENGTH;
  localparam int CW = COUNT_LENGTH;
  localparam logic [CW-1:0] DIV_ONE = CW'(1'b1);

  logic [OW-1:0] offset_r;
  logic [OW-1:0] min_r;
  logic [OW-1:0] max_r;
  logic [OW-1:0] step_r;
  logic          dir_up_r;
  logic [CW-1:0] div_cnt_r;
  logic [CW-1:0] div_last_r;

  logic [OW:0]   up_sum_s;
  logic [OW:0]   dn_floor_s;
  logic          inverted_s;
  logic          div_done_s;
  logic          step_now_s;
  logic [OW-1:0] offset_nxt_s;
  logic          dir_up_nxt_s;

  // Next ramp position; sums are one bit wider so neither bound test can wrap.
  always_comb begin
    up_sum_s     = {1'b0, offset_r} + {1'b0, step_r};
    dn_floor_s   = {1'b0, min_r} + {1'b0, step_r};
    inverted_s   = (min_r > max_r);
    div_done_s   = (div_cnt_r == div_last_r);
    step_now_s   = run && tick && div_done_s && !inverted_s;
    offset_nxt_s = offset_r;
    dir_up_nxt_s = dir_up_r;
    top_flip     = 1'b0;
    if (step_now_s) begin
      if (dir_up_r) begin
        if (up_sum_s >= {1'b0, max_r}) begin
          offset_nxt_s = max_r;
          dir_up_nxt_s = 1'b0;
          top_flip     = 1'b1;
        end else begin
          offset_nxt_s = up_sum_s[OW-1:0];
        end
      end else begin
        // Landing exactly on min+step also turns around, mirroring the top
        // bound, so the ramp does not dwell an extra step at sweep_min.
        if ({1'b0, offset_r} <= dn_floor_s) begin
          offset_nxt_s = min_r;
          dir_up_nxt_s = 1'b1;
        end else begin
          offset_nxt_s = offset_r - step_r;
        end
      end
    end else begin
      offset_nxt_s = offset_r;
    end
  end

  // Ramp registers: config latch on load, otherwise advance only while running.
  // The divider holds while frozen, so a resumed sweep keeps its phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offset_r   <= {OW{1'b0}};
      min_r      <= {OW{1'b0}};
      max_r      <= {OW{1'b0}};
      step_r     <= {OW{1'b0}};
      dir_up_r   <= 1'b1;
      div_cnt_r  <= {CW{1'b0}};
      div_last_r <= {CW{1'b0}};
    end else if (load) begin
      offset_r   <= sweep_min;
      min_r      <= sweep_min;
      max_r      <= sweep_max;
      step_r     <= sweep_step;
      dir_up_r   <= 1'b1;
      div_cnt_r  <= {CW{1'b0}};
      div_last_r <= (step_div == {CW{1'b0}}) ? {CW{1'b0}} : (step_div - DIV_ONE);
    end else if (run && tick) begin
      offset_r   <= offset_nxt_s;
      dir_up_r   <= dir_up_nxt_s;
      div_cnt_r  <= div_done_s ? {CW{1'b0}} : (div_cnt_r + DIV_ONE);
    end
  end

  assign offset = offset_r;

endmodule

// File: rtl/opo_lock_sequencer.sv
// opo_lock_sequencer
// Acquisition/relock controller for the OPO lock-in chain. Sweeps the piezo
// offset as a triangle until y_in reaches amp_thresh, hands over to the PID,
// waits for the signal to settle, supervises lock and re-sweeps on loss.
// Optional macro OPO_LOCK_SWEEP_TIMEOUT_EN adds sweep_limit and the FAULT state
// (too many full sweeps without capture); without it fault is always 0.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   enable              : run request, 0 forces IDLE
//   x_in, y_in          : signed lock-in error / amplitude samples
//   xy_valid            : one-cycle strobe for new x_in/y_in
//   sweep_min/max/step  : triangle bounds and increment (latched at start)
//   step_div            : samples per sweep step, 0 behaves as 1
//   amp_thresh          : signed capture/hold threshold on y_in
//   settle_len          : in-threshold samples required before LOCKED
//   loss_len            : consecutive low samples declaring loss, 0 behaves as 1
//   sweep_limit         : full sweeps allowed before FAULT (macro only, 0 = off)
//   offset_out          : piezo offset command
//   pid_en, locked      : PID integrator enable, lock achieved
//   state_out           : state encoding (lock_state_t)
//   relock_cnt          : saturating count of lock losses
//   fault               : sweep timeout flag
module opo_lock_sequencer
  import opo_lock_pkg::*;
#(
  parameter int CART_LENGTH   = CART_W,
  parameter int OFFSET_LENGTH = OFFSET_W,
  parameter int COUNT_LENGTH  = COUNT_W,
  parameter int RELOCK_LENGTH = RELOCK_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic signed [CART_LENGTH-1:0] x_in,
  input  logic signed [CART_LENGTH-1:0] y_in,
  input  logic                          xy_valid,
  input  logic [OFFSET_LENGTH-1:0]      sweep_min,
  input  logic [OFFSET_LENGTH-1:0]      sweep_max,
  input  logic [OFFSET_LENGTH-1:0]      sweep_step,
  input  logic [COUNT_LENGTH-1:0]       step_div,
  input  logic signed [CART_LENGTH-1:0] amp_thresh,
  input  logic [COUNT_LENGTH-1:0]       settle_len,
  input  logic [COUNT_LENGTH-1:0]       loss_len,
`ifdef OPO_LOCK_SWEEP_TIMEOUT_EN
  input  logic [7:0]                    sweep_limit,
`endif
  output logic [OFFSET_LENGTH-1:0]      offset_out,
  output logic                          pid_en,
  output logic                          locked,
  output logic [STATE_W-1:0]            state_out,
  output logic [RELOCK_LENGTH-1:0]      relock_cnt,
  output logic                          fault
);

  localparam int CL  = CART_LENGTH;
  localparam int NL  = COUNT_LENGTH;
  localparam int RL  = RELOCK_LENGTH;
  localparam int EXT = CMP_W - CART_LENGTH;
  localparam logic [NL:0]   CNT_INC = (NL+1)'(1'b1);
  localparam logic [NL-1:0] CNT_ONE = NL'(1'b1);
  localparam logic [RL-1:0] RLK_ONE = RL'(1'b1);

  lock_state_t         state_r;
  logic                pid_en_r;
  logic                locked_r;
  logic                fault_r;
  logic [RL-1:0]       relock_r;
  logic [NL-1:0]       settle_cnt_r;
  logic [NL-1:0]       loss_cnt_r;
  logic signed [CL-1:0] thresh_r;
  logic [NL-1:0]       settle_len_r;
  logic [NL-1:0]       loss_max_r;

  logic [CMP_W-1:0]    y_ext_s;
  logic [CMP_W-1:0]    thresh_ext_s;
  logic                y_ok_s;
  logic                start_s;
  logic                capture_s;
  logic                sweep_run_s;
  logic [NL:0]         settle_inc_s;
  logic [NL:0]         loss_inc_s;
  logic                top_flip_s;
  logic                unused_s;

`ifdef OPO_LOCK_SWEEP_TIMEOUT_EN
  logic [7:0]          limit_r;
  logic [7:0]          sweep_cnt_r;
  logic [8:0]          sweep_inc_s;
  logic                timeout_s;
`endif

  // Threshold test and per-cycle sequencing decisions.
  always_comb begin
    y_ext_s      = {{EXT{y_in[CL-1]}}, y_in};
    thresh_ext_s = {{EXT{thresh_r[CL-1]}}, thresh_r};
    y_ok_s       = sge(y_ext_s, thresh_ext_s);
    start_s      = enable && (state_r == IDLE);
    capture_s    = (state_r == SWEEP) && xy_valid && y_ok_s;
    // A capturing sample freezes the ramp even if the divider expires with it.
    sweep_run_s  = enable && (state_r == SWEEP) && !capture_s;
    settle_inc_s = {1'b0, settle_cnt_r} + CNT_INC;
    loss_inc_s   = {1'b0, loss_cnt_r} + CNT_INC;
  end

`ifdef OPO_LOCK_SWEEP_TIMEOUT_EN
  // A full sweep is one turnaround at sweep_max; limit 0 disables the timeout.
  always_comb begin
    sweep_inc_s = {1'b0, sweep_cnt_r} + 9'd1;
    timeout_s   = top_flip_s && (limit_r != 8'd0) && (sweep_inc_s >= {1'b0, limit_r});
  end

  // Full-sweep counter, cleared whenever the ramp restarts or captures.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      limit_r     <= 8'd0;
      sweep_cnt_r <= 8'd0;
    end else if (!enable || capture_s) begin
      sweep_cnt_r <= 8'd0;
    end else if (start_s) begin
      limit_r     <= sweep_limit;
      sweep_cnt_r <= 8'd0;
    end else if ((state_r == SWEEP) && top_flip_s) begin
      sweep_cnt_r <= sweep_inc_s[7:0];
    end
  end

  assign unused_s = ^x_in;
`else
  // x_in feeds the PID downstream, and top_flip only matters for the timeout.
  assign unused_s = ^{x_in, top_flip_s};
`endif

  // Sequencer FSM with registered outputs; enable=0 overrides every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      pid_en_r     <= 1'b0;
      locked_r     <= 1'b0;
      fault_r      <= 1'b0;
      relock_r     <= {RL{1'b0}};
      settle_cnt_r <= {NL{1'b0}};
      loss_cnt_r   <= {NL{1'b0}};
      thresh_r     <= {CL{1'b0}};
      settle_len_r <= {NL{1'b0}};
      loss_max_r   <= {NL{1'b0}};
    end else if (!enable) begin
      state_r      <= IDLE;
      pid_en_r     <= 1'b0;
      locked_r     <= 1'b0;
      fault_r      <= 1'b0;
      settle_cnt_r <= {NL{1'b0}};
      loss_cnt_r   <= {NL{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          state_r      <= SWEEP;
          pid_en_r     <= 1'b0;
          locked_r     <= 1'b0;
          thresh_r     <= amp_thresh;
          settle_len_r <= settle_len;
          loss_max_r   <= (loss_len == {NL{1'b0}}) ? CNT_ONE : loss_len;
        end
        SWEEP: begin
          pid_en_r <= 1'b0;
          locked_r <= 1'b0;
          if (capture_s) begin
            state_r      <= SETTLE;
            pid_en_r     <= 1'b1;
            settle_cnt_r <= {NL{1'b0}};
          end
`ifdef OPO_LOCK_SWEEP_TIMEOUT_EN
          else if (timeout_s) begin
            state_r <= FAULT;
            fault_r <= 1'b1;
          end
`endif
        end
        SETTLE: begin
          pid_en_r <= 1'b1;
          if (settle_len_r == {NL{1'b0}}) begin
            state_r    <= LOCKED;
            locked_r   <= 1'b1;
            loss_cnt_r <= {NL{1'b0}};
          end else if (xy_valid) begin
            if (!y_ok_s) begin
              state_r      <= SWEEP;
              pid_en_r     <= 1'b0;
              settle_cnt_r <= {NL{1'b0}};
            end else if (settle_inc_s >= {1'b0, settle_len_r}) begin
              state_r      <= LOCKED;
              locked_r     <= 1'b1;
              settle_cnt_r <= {NL{1'b0}};
              loss_cnt_r   <= {NL{1'b0}};
            end else begin
              settle_cnt_r <= settle_inc_s[NL-1:0];
            end
          end
        end
        LOCKED: begin
          pid_en_r <= 1'b1;
          locked_r <= 1'b1;
          if (xy_valid) begin
            if (y_ok_s) begin
              loss_cnt_r <= {NL{1'b0}};
            end else if (loss_inc_s >= {1'b0, loss_max_r}) begin
              state_r    <= SWEEP;
              pid_en_r   <= 1'b0;
              locked_r   <= 1'b0;
              loss_cnt_r <= {NL{1'b0}};
              if (relock_r != {RL{1'b1}}) begin
                relock_r <= relock_r + RLK_ONE;
              end
            end else begin
              loss_cnt_r <= loss_inc_s[NL-1:0];
            end
          end
        end
        FAULT: begin
          pid_en_r <= 1'b0;
          locked_r <= 1'b0;
          fault_r  <= 1'b1;
        end
        default: begin
          state_r  <= IDLE;
          pid_en_r <= 1'b0;
          locked_r <= 1'b0;
          fault_r  <= 1'b0;
        end
      endcase
    end
  end

  sweep_gen #(
    .OFFSET_LENGTH (OFFSET_LENGTH),
    .COUNT_LENGTH  (COUNT_LENGTH)
  ) u_sweep_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (start_s),
    .run        (sweep_run_s),
    .tick       (xy_valid),
    .sweep_min  (sweep_min),
    .sweep_max  (sweep_max),
    .sweep_step (sweep_step),
    .step_div   (step_div),
    .offset     (offset_out),
    .top_flip   (top_flip_s)
  );

  assign pid_en     = pid_en_r;
  assign locked     = locked_r;
  assign fault      = fault_r;
  assign state_out  = state_r;
  assign relock_cnt = relock_r;

endmodule
